// File: rtl/cic3_row_readout.sv
// Readout scheduler for one row of CIC3 decimation filters.
// On an accepted sample strobe the row outputs and channel mask are captured.
// The enabled channels are then streamed lowest-first as {id, sample} words
// over valid/ready. Strobes lost to back-pressure are counted as overruns.

// One shadow register per filter, loaded when a frame is accepted.
module cic3_shadow_lane #(
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    // Hold the captured sample for the whole frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (cap)  q <= d;
    end
endmodule

module cic3_row_readout #(
    parameter int NUM_FILTERS = 24,
    parameter int DATA_W      = 25,
    parameter int CHAN_W      = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_FILTERS-1:0]        chan_mask,
    input  logic [NUM_FILTERS*DATA_W-1:0] filt_out,
    input  logic                          sample_strobe,
    input  logic                          ovr_clear,
    output logic [CHAN_W+DATA_W-1:0]      dout_data,
    output logic                          dout_first,
    output logic                          dout_last,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          overrun,
    output logic [7:0]                    drop_count,
    output logic [15:0]                   frame_count
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                               state;
    logic [NUM_FILTERS-1:0][DATA_W-1:0]   filt_arr;
    logic [NUM_FILTERS-1:0][DATA_W-1:0]   shadow;
    logic [NUM_FILTERS-1:0]               pending;
    logic [CHAN_W-1:0]                    hi_ch;

    logic [CHAN_W-1:0]                    cur_ch;
    logic [NUM_FILTERS-1:0]               cur_oh;
    logic [NUM_FILTERS-1:0]               rem;
    logic [CHAN_W-1:0]                    nxt_ch;
    logic [CHAN_W-1:0]                    new_ch;
    logic [CHAN_W-1:0]                    new_hi;
    logic                                 hs;
    logic                                 final_hs;
    logic                                 start_req;
    logic                                 start;
    logic                                 ovr_ev;

    function automatic logic [CHAN_W-1:0] lsb_idx(input logic [NUM_FILTERS-1:0] m);
        lsb_idx = '0;
        for (int i = NUM_FILTERS-1; i >= 0; i--)
            if (m[i]) lsb_idx = CHAN_W'(i);
    endfunction

    function automatic logic [CHAN_W-1:0] msb_idx(input logic [NUM_FILTERS-1:0] m);
        msb_idx = '0;
        for (int i = 0; i < NUM_FILTERS; i++)
            if (m[i]) msb_idx = CHAN_W'(i);
    endfunction

    assign filt_arr  = filt_out;
    assign busy      = (state == SEND);
    assign cur_ch    = dout_data[DATA_W +: CHAN_W];
    assign cur_oh    = NUM_FILTERS'(1) << cur_ch;
    assign rem       = pending & ~cur_oh;
    assign nxt_ch    = lsb_idx(rem);
    assign new_ch    = lsb_idx(chan_mask);
    assign new_hi    = msb_idx(chan_mask);
    assign hs        = dout_valid & dout_ready;
    // Last word of the frame is accepted this cycle; a strobe here is a
    // legal back-to-back frame start rather than an overrun.
    assign final_hs  = hs & dout_last;
    assign start_req = sample_strobe & enable & (|chan_mask);
    assign start     = start_req & ((state == IDLE) | final_hs);
    assign ovr_ev    = (state == SEND) & sample_strobe & enable & ~final_hs;

    genvar g;
    generate
        for (g = 0; g < NUM_FILTERS; g++) begin : g_lane
            cic3_shadow_lane #(.DATA_W(DATA_W)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .cap     (start),
                .d       (filt_arr[g]),
                .q       (shadow[g])
            );
        end
    endgenerate

    // Frame sequencer: owns the output register, pending mask and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= '0;
            hi_ch       <= '0;
            dout_data   <= '0;
            dout_first  <= 1'b0;
            dout_last   <= 1'b0;
            dout_valid  <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending    <= chan_mask;
                        hi_ch      <= new_hi;
                        dout_data  <= {new_ch, filt_arr[new_ch]};
                        dout_first <= 1'b1;
                        dout_last  <= (new_ch == new_hi);
                        dout_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (rem != '0) begin
                            pending    <= rem;
                            dout_data  <= {nxt_ch, shadow[nxt_ch]};
                            dout_first <= 1'b0;
                            dout_last  <= (nxt_ch == hi_ch);
                        end else begin
                            frame_count <= frame_count + 16'd1;
                            if (start) begin
                                // New frame loads directly from the live inputs,
                                // keeping dout_valid high with no bubble.
                                pending    <= chan_mask;
                                hi_ch      <= new_hi;
                                dout_data  <= {new_ch, filt_arr[new_ch]};
                                dout_first <= 1'b1;
                                dout_last  <= (new_ch == new_hi);
                            end else begin
                                pending    <= '0;
                                dout_first <= 1'b0;
                                dout_last  <= 1'b0;
                                dout_valid <= 1'b0;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun and saturating drop counter; a new drop beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (ovr_ev) begin
            overrun    <= 1'b1;
            if (ovr_clear)                drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (ovr_clear) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_cic3_row_readout.sv
// Directed bench for cic3_row_readout: vector table plus hand sequences for
// back-to-back frames, overrun/clear and mid-frame reset.
module tb_cic3_row_readout;
    localparam int NF = 24;
    localparam int DW = 25;
    localparam int CW = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                enable = 1'b0;
    logic [NF-1:0]       chan_mask = '0;
    logic [NF*DW-1:0]    filt_out = '0;
    logic                sample_strobe = 1'b0;
    logic                ovr_clear = 1'b0;
    logic [CW+DW-1:0]    dout_data;
    logic                dout_first;
    logic                dout_last;
    logic                dout_valid;
    logic                dout_ready = 1'b1;
    logic                busy;
    logic                overrun;
    logic [7:0]          drop_count;
    logic [15:0]         frame_count;

    cic3_row_readout #(.NUM_FILTERS(NF), .DATA_W(DW), .CHAN_W(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .chan_mask     (chan_mask),
        .filt_out      (filt_out),
        .sample_strobe (sample_strobe),
        .ovr_clear     (ovr_clear),
        .dout_data     (dout_data),
        .dout_first    (dout_first),
        .dout_last     (dout_last),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .busy          (busy),
        .overrun       (overrun),
        .drop_count    (drop_count),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int t0     = 0;
    logic [NF-1:0] cur_mask;
    int            cur_pat;

    logic [CW-1:0] got_id[$];
    logic [DW-1:0] got_dat[$];
    bit            got_first[$];
    bit            got_last[$];
    int            got_cyc[$];
    int            stab_err;

    typedef struct {
        logic [NF-1:0] mask;
        bit            en;
        bit            rnd;
        int            n;
        int            fid;
        int            lid;
        int            pat;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat_val(input int p, input int k);
        case (p)
            0:       pat_val = DW'(k) + 25'h100000;
            1:       pat_val = 25'h1F0000 ^ DW'(k * 273);
            2:       pat_val = 25'h0ABCD0 + DW'(k * 7);
            default: pat_val = 25'h0DEAD00 ^ DW'(k);
        endcase
    endfunction

    task automatic fill(input int p);
        for (int k = 0; k < NF; k++) filt_out[k*DW +: DW] = pat_val(p, k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-cycle strobe; afterwards scramble inputs so the frame must come from the snapshot.
    task automatic strobe(input logic [NF-1:0] m, input bit en, input int p);
        chan_mask = m; enable = en; fill(p);
        sample_strobe = 1'b1;
        t0 = cyc;
        step();
        sample_strobe = 1'b0;
        enable = 1'b1;
        cur_mask = m; cur_pat = p;
        chan_mask = ~m;
        fill(3);
    endtask

    // Drain one frame; optional extra strobes/clear while word index sa/sb/clr_at is presented.
    task automatic run_frame(input bit rnd, input int sa, input int sb, input int clr_at, input int budget);
        bit done = 0;
        bit hold = 0;
        bit rdy;
        int widx = 0;
        logic [CW+DW+1:0] h_word = '0;
        got_id.delete(); got_dat.delete(); got_first.delete(); got_last.delete(); got_cyc.delete();
        stab_err = 0;
        for (int c = 0; c < budget && !done; c++) begin
            if (hold && {dout_first, dout_last, dout_data} !== h_word) stab_err++;
            sample_strobe = dout_valid && (widx == sa || widx == sb);
            ovr_clear     = dout_valid && (widx == clr_at);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = rdy;
            if (dout_valid && rdy) begin
                got_id.push_back(dout_data[DW +: CW]);
                got_dat.push_back(dout_data[DW-1:0]);
                got_first.push_back(dout_first);
                got_last.push_back(dout_last);
                got_cyc.push_back(cyc);
                if (dout_last) done = 1;
                widx++;
            end
            hold   = dout_valid && !rdy;
            h_word = {dout_first, dout_last, dout_data};
            step();
        end
        sample_strobe = 1'b0; ovr_clear = 1'b0; dout_ready = 1'b1;
        if (!done) check("frame_timeout", 64'(got_id.size()), 64'hFFFF);
    endtask

    // Compare collected words against the expected list derived from the captured mask.
    task automatic verify_frame(input string name);
        int k = 0;
        int n = 0;
        for (int i = 0; i < NF; i++) if (cur_mask[i]) n++;
        check({name, "_count"}, 64'(got_id.size()), 64'(n));
        for (int i = 0; i < NF; i++) begin
            if (cur_mask[i] && k < got_id.size()) begin
                check({name, "_word"},
                      {32'd0, got_first[k], got_last[k], got_id[k], got_dat[k]},
                      {32'd0, (k == 0), (k == n - 1), CW'(i), pat_val(cur_pat, i)});
                k++;
            end
        end
        check({name, "_stable"}, 64'(stab_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc0;
        bit seen;

        vt[0] = '{24'h000005, 1, 0,  2,  0,  2, 1};
        vt[1] = '{24'h800000, 1, 0,  1, 23, 23, 2};
        vt[2] = '{24'h000000, 1, 0,  0,  0,  0, 0};
        vt[3] = '{24'hFFFFFF, 0, 0,  0,  0,  0, 0};
        vt[4] = '{24'h100100, 1, 0,  2,  8, 20, 1};
        vt[5] = '{24'hA5A5A5, 1, 1, 12,  0, 23, 2};
        vt[6] = '{24'hFFFFFF, 1, 1, 24,  0, 23, 0};

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_valid", 64'(dout_valid), 0);
        check("rst_busy",  64'(busy), 0);
        check("rst_data",  64'(dout_data), 0);
        check("rst_flags", {62'd0, dout_first, dout_last}, 0);
        check("rst_ovr",   {55'd0, overrun, drop_count}, 0);
        check("rst_fc",    64'(frame_count), 0);
        repeat (3) step();
        reset_n = 1'b1;
        cyc = 0;
        repeat (9) step();

        // Full row, ready held high: word j in cycle N+1+j, idle at N+25
        strobe(24'hFFFFFF, 1, 0);
        run_frame(0, -1, -1, -1, 100);
        verify_frame("full");
        for (int j = 0; j < got_cyc.size(); j++) check("full_timing", 64'(got_cyc[j]), 64'(t0 + 1 + j));
        check("full_busy_end", 64'(busy), 0);
        check("full_cyc_end", 64'(cyc), 64'(t0 + 25));
        check("full_fc", 64'(frame_count), 1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            fc0 = frame_count;
            strobe(vt[v].mask, vt[v].en, vt[v].pat);
            if (vt[v].n == 0) begin
                seen = 0;
                for (int c = 0; c < 5; c++) begin
                    if (dout_valid || busy) seen = 1;
                    step();
                end
                check("vec_no_output", 64'(seen), 0);
            end else begin
                run_frame(vt[v].rnd, -1, -1, -1, 400);
                verify_frame("vec");
                check("vec_n", 64'(got_id.size()), 64'(vt[v].n));
                if (got_id.size() > 0) begin
                    check("vec_first_id", 64'(got_id[0]), 64'(vt[v].fid));
                    check("vec_last_id",  64'(got_id[got_id.size()-1]), 64'(vt[v].lid));
                end
            end
            check("vec_overrun", 64'(overrun), 0);
            check("vec_fc", 64'(frame_count), 64'(fc0 + (vt[v].n > 0 ? 1 : 0)));
        end

        // Strobe coincident with final handshake: back-to-back frame, no bubble
        fc0 = frame_count;
        strobe(24'h000005, 1, 0);
        check("b2b_w0", {32'd0, dout_valid, dout_first, dout_data}, {32'd0, 1'b1, 1'b1, 5'd0, pat_val(0, 0)});
        step();
        check("b2b_w1", {32'd0, dout_valid, dout_last, dout_data}, {32'd0, 1'b1, 1'b1, 5'd2, pat_val(0, 2)});
        chan_mask = 24'h000003; fill(1); sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0; cur_mask = 24'h000003; cur_pat = 1; fill(3);
        check("b2b_new_w0", {32'd0, dout_valid, dout_first, dout_last, dout_data},
                            {32'd0, 1'b1, 1'b1, 1'b0, 5'd0, pat_val(1, 0)});
        check("b2b_no_ovr", {55'd0, overrun, drop_count}, 0);
        check("b2b_fc1", 64'(frame_count), 64'(fc0 + 1));
        run_frame(0, -1, -1, -1, 50);
        verify_frame("b2b");
        check("b2b_fc2", 64'(frame_count), 64'(fc0 + 2));

        // Overrun mid-frame leaves the frame intact
        strobe(24'hFFFFFF, 1, 0);
        run_frame(0, 5, -1, -1, 100);
        verify_frame("ovr");
        check("ovr_flag", 64'(overrun), 1);
        check("ovr_drops", 64'(drop_count), 1);
        check("ovr_busy", 64'(busy), 0);

        ovr_clear = 1'b1;
        step();
        ovr_clear = 1'b0;
        check("clr_alone", {55'd0, overrun, drop_count}, 0);

        // Drop, then drop plus clear in the same cycle: set wins, count restarts at 1
        strobe(24'hFFFFFF, 1, 1);
        run_frame(0, 3, 7, 7, 100);
        verify_frame("ovr2");
        check("clr_coinc_flag", 64'(overrun), 1);
        check("clr_coinc_drops", 64'(drop_count), 1);

        // Asynchronous reset mid-frame
        strobe(24'hFFFFFF, 1, 0);
        step(); step();
        check("pre_rst_valid", 64'(dout_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {61'd0, dout_valid, dout_first, busy}, 0);
        check("mid_rst_data", 64'(dout_data), 0);
        check("mid_rst_cnt", {39'd0, overrun, drop_count, frame_count}, 0);
        #1 reset_n = 1'b1;
        step();
        check("post_rst_idle", {62'd0, busy, dout_valid}, 0);
        strobe(24'h000005, 1, 2);
        run_frame(0, -1, -1, -1, 50);
        verify_frame("post_rst");
        check("post_rst_fc", 64'(frame_count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
